iddmm_result_sel: RTL and testbench

//  Final-result stage directly downstream of iddmm_cal. Buffers the N-word candidate result (a)
//  and the N-word reduced candidate (a - p) streamed out of the IDDMM pipeline.
//  On cal_done it selects one buffer by cal_sign and drains it LSW-first over a valid/ready port.

---
 rtl/iddmm_result_sel.sv | 165 ++++++++++++++++
 tb/tb_iddmm_result_sel.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iddmm_result_sel.sv
// ---------------------------------------------------------------------------
// iddmm_result_sel
//
// Final-result stage behind iddmm_cal. Two N-word buffers collect the
// candidate result (a) and the reduced candidate (a - p) as they stream out
// of the IDDMM pipeline, LSW first. Once both buffers are full and cal_done
// has been seen, the buffer chosen by cal_sign is drained LSW-first over a
// valid/ready port. Upstream cannot be stalled, so anything that arrives
// while it cannot be stored is dropped and flagged on the sticky err_ovf.
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous active-high reset
//   fifo_wr_en_a      candidate-a word strobe
//   fifo_wr_data_a    candidate-a word
//   fifo_wr_en_sub    candidate-(a-p) word strobe
//   fifo_wr_data_sub  candidate-(a-p) word
//   cal_done          1-cycle end-of-operation pulse, qualifies cal_sign
//   cal_sign          1 selects the (a-p) buffer, 0 selects the a buffer
//   o_valid           output word valid
//   o_data            output word
//   o_addr            output word index 0..N-1
//   o_last            high together with word N-1
//   i_ready           downstream accepts when o_valid & i_ready
//   busy              an operation is being collected or drained
//   err_ovf           sticky overrun flag, cleared only by rst
// ---------------------------------------------------------------------------
module iddmm_result_sel #(
    parameter int K      = 256,
    parameter int N      = 16,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_wr_en_a,
    input  logic [K-1:0]      fifo_wr_data_a,
    input  logic              fifo_wr_en_sub,
    input  logic [K-1:0]      fifo_wr_data_sub,
    input  logic              cal_done,
    input  logic              cal_sign,
    output logic              o_valid,
    output logic [K-1:0]      o_data,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last,
    input  logic              i_ready,
    output logic              busy,
    output logic              err_ovf
);

    localparam logic [ADDR_W:0]   FULL    = (ADDR_W+1)'(N);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(N-1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [K-1:0]      buf_a   [N];
    logic [K-1:0]      buf_sub [N];
    logic [ADDR_W:0]   cnt_a, cnt_a_nxt;
    logic [ADDR_W:0]   cnt_sub, cnt_sub_nxt;
    logic              done_seen, done_seen_nxt;
    logic              sel, sel_nxt;
    logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic              ovf_nxt;
    logic              wr_a_ok, wr_sub_ok;

    // A word is only stored while collecting and while its buffer has room;
    // counters are one bit wider than the index so "full" is representable.
    assign wr_a_ok   = (state == COLLECT) && fifo_wr_en_a   && (cnt_a   != FULL);
    assign wr_sub_ok = (state == COLLECT) && fifo_wr_en_sub && (cnt_sub != FULL);

    // Buffers are plain storage with no reset; stale contents are never
    // presented because draining only starts after a full refill.
    always_ff @(posedge clk) begin
        if (!rst && wr_a_ok)
            buf_a[cnt_a[ADDR_W-1:0]] <= fifo_wr_data_a;
        if (!rst && wr_sub_ok)
            buf_sub[cnt_sub[ADDR_W-1:0]] <= fifo_wr_data_sub;
    end

    // State and control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            cnt_a     <= '0;
            cnt_sub   <= '0;
            done_seen <= 1'b0;
            sel       <= 1'b0;
            rd_ptr    <= '0;
            err_ovf   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt_a     <= cnt_a_nxt;
            cnt_sub   <= cnt_sub_nxt;
            done_seen <= done_seen_nxt;
            sel       <= sel_nxt;
            rd_ptr    <= rd_ptr_nxt;
            err_ovf   <= ovf_nxt;
        end
    end

    // Next-state logic. The switch to DRAIN looks at the post-update counts
    // and done flag so a final word or done arriving on that very edge still
    // lets the drain begin on the following cycle. In DRAIN every input is
    // an overrun, including on the edge of the last handshake.
    always_comb begin
        state_nxt     = state;
        cnt_a_nxt     = cnt_a;
        cnt_sub_nxt   = cnt_sub;
        done_seen_nxt = done_seen;
        sel_nxt       = sel;
        rd_ptr_nxt    = rd_ptr;
        ovf_nxt       = err_ovf;
        case (state)
            COLLECT: begin
                if (wr_a_ok)
                    cnt_a_nxt = cnt_a + CNT_ONE;
                else if (fifo_wr_en_a)
                    ovf_nxt = 1'b1;
                if (wr_sub_ok)
                    cnt_sub_nxt = cnt_sub + CNT_ONE;
                else if (fifo_wr_en_sub)
                    ovf_nxt = 1'b1;
                if (cal_done) begin
                    if (done_seen) begin
                        ovf_nxt = 1'b1;
                    end else begin
                        done_seen_nxt = 1'b1;
                        sel_nxt       = cal_sign;
                    end
                end
                if ((cnt_a_nxt == FULL) && (cnt_sub_nxt == FULL) && done_seen_nxt) begin
                    state_nxt  = DRAIN;
                    rd_ptr_nxt = '0;
                end
            end
            DRAIN: begin
                if (fifo_wr_en_a || fifo_wr_en_sub || cal_done)
                    ovf_nxt = 1'b1;
                if (i_ready) begin
                    if (rd_ptr == LAST) begin
                        state_nxt     = COLLECT;
                        cnt_a_nxt     = '0;
                        cnt_sub_nxt   = '0;
                        done_seen_nxt = 1'b0;
                        rd_ptr_nxt    = '0;
                    end else begin
                        rd_ptr_nxt = rd_ptr + PTR_ONE;
                    end
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    // Output port is a direct view of the read pointer and selected buffer,
    // forced to zero when nothing is being offered.
    assign o_valid = (state == DRAIN);
    assign o_addr  = o_valid ? rd_ptr : '0;
    assign o_last  = o_valid && (rd_ptr == LAST);
    assign o_data  = !o_valid ? '0 : (sel ? buf_sub[rd_ptr] : buf_a[rd_ptr]);
    assign busy    = o_valid || (cnt_a != '0) || (cnt_sub != '0) || done_seen;

endmodule

// File: tb/tb_iddmm_result_sel.sv
// ---------------------------------------------------------------------------
// tb_iddmm_result_sel
//
// Directed bench for iddmm_result_sel. A queue-based model collects the two
// streams, decides when a result is complete and which words must come out;
// a negedge process compares the DUT against it every cycle, and each
// scenario adds literal checks on the words actually received.
// ---------------------------------------------------------------------------
module tb_iddmm_result_sel;

    localparam int K      = 256;
    localparam int N      = 16;
    localparam int ADDR_W = $clog2(N);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fifo_wr_en_a = 1'b0;
    logic [K-1:0]      fifo_wr_data_a = '0;
    logic              fifo_wr_en_sub = 1'b0;
    logic [K-1:0]      fifo_wr_data_sub = '0;
    logic              cal_done = 1'b0;
    logic              cal_sign = 1'b0;
    logic              o_valid;
    logic [K-1:0]      o_data;
    logic [ADDR_W-1:0] o_addr;
    logic              o_last;
    logic              i_ready = 1'b0;
    logic              busy;
    logic              err_ovf;

    int num_checks = 0;
    int num_fail   = 0;
    bit check_en   = 1'b0;

    logic [K-1:0] got_q [$];

    // Model state: words stored so far, pending done/sign, and the word list
    // being handed out together with the position of the next one.
    logic [K-1:0] m_a   [$];
    logic [K-1:0] m_sub [$];
    logic [K-1:0] m_exp [$];
    bit           m_done     = 1'b0;
    bit           m_sign     = 1'b0;
    bit           m_draining = 1'b0;
    int           m_pos      = 0;
    bit           m_ovf      = 1'b0;

    iddmm_result_sel #(.K(K), .N(N), .ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .fifo_wr_en_a     (fifo_wr_en_a),
        .fifo_wr_data_a   (fifo_wr_data_a),
        .fifo_wr_en_sub   (fifo_wr_en_sub),
        .fifo_wr_data_sub (fifo_wr_data_sub),
        .cal_done         (cal_done),
        .cal_sign         (cal_sign),
        .o_valid          (o_valid),
        .o_data           (o_data),
        .o_addr           (o_addr),
        .o_last           (o_last),
        .i_ready          (i_ready),
        .busy             (busy),
        .err_ovf          (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of input drive, applied just after the rising edge.
    task automatic applyStimulus(input logic wa, input logic [K-1:0] da,
                                 input logic ws, input logic [K-1:0] ds,
                                 input logic done, input logic sign);
        @(posedge clk); #1;
        fifo_wr_en_a     = wa;
        fifo_wr_data_a   = da;
        fifo_wr_en_sub   = ws;
        fifo_wr_data_sub = ds;
        cal_done         = done;
        cal_sign         = sign;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Keeps accepting until o_valid drops; stall_mode 1 drives i_ready with
    // the repeating 1,0,0,1 pattern, inject_at puts one sub strobe mid-drain.
    task automatic drainWait(input int stall_mode, input int inject_at);
        int c = 0;
        do begin
            @(posedge clk); #1;
            i_ready          = (stall_mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
            fifo_wr_en_sub   = (c == inject_at);
            fifo_wr_data_sub = 256'hDEAD;
            c++;
        end while ((o_valid || c < 2) && c < 300);
        if (o_valid) checkOutput("drain_timeout", 1'b1, 1'b0);
        fifo_wr_en_sub = 1'b0;
        i_ready        = 1'b0;
    endtask

    // Model update from the inputs seen at each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_a.delete(); m_sub.delete(); m_exp.delete();
            m_done = 1'b0; m_draining = 1'b0; m_pos = 0; m_ovf = 1'b0;
        end else if (m_draining) begin
            if (fifo_wr_en_a || fifo_wr_en_sub || cal_done) m_ovf = 1'b1;
            if (i_ready) begin
                if (m_pos == N - 1) begin
                    m_draining = 1'b0; m_pos = 0; m_done = 1'b0;
                    m_a.delete(); m_sub.delete();
                end else begin
                    m_pos++;
                end
            end
        end else begin
            if (fifo_wr_en_a) begin
                if (m_a.size() < N) m_a.push_back(fifo_wr_data_a);
                else m_ovf = 1'b1;
            end
            if (fifo_wr_en_sub) begin
                if (m_sub.size() < N) m_sub.push_back(fifo_wr_data_sub);
                else m_ovf = 1'b1;
            end
            if (cal_done) begin
                if (m_done) m_ovf = 1'b1;
                else begin m_done = 1'b1; m_sign = cal_sign; end
            end
            if (m_a.size() == N && m_sub.size() == N && m_done) begin
                m_draining = 1'b1;
                m_pos = 0;
                if (m_sign) m_exp = m_sub;
                else m_exp = m_a;
            end
        end
    end

    // Every-cycle comparison against the model, plus capture of accepted words.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("o_valid", o_valid, m_draining);
            checkOutput("busy", busy, m_draining || m_a.size() != 0 || m_sub.size() != 0 || m_done);
            checkOutput("err_ovf", err_ovf, m_ovf);
            if (m_draining) begin
                checkOutput("o_data", o_data, m_exp[m_pos]);
                checkOutput("o_addr", o_addr, m_pos);
                checkOutput("o_last", o_last, m_pos == N - 1);
            end
            if (o_valid && i_ready) got_q.push_back(o_data);
        end
    end

    initial begin
        int c;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("rst_o_valid", o_valid, 1'b0);
        checkOutput("rst_o_data", o_data, '0);
        checkOutput("rst_o_addr", o_addr, '0);
        checkOutput("rst_o_last", o_last, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_err_ovf", err_ovf, 1'b0);
        check_en = 1'b1;

        // 1: interleaved streams, sign=1 selects the sub buffer
        got_q.delete();
        for (int j = 0; j < N; j++) begin
            applyStimulus(1'b1, 256'(j + 1), 1'b0, '0, 1'b0, 1'b0);
            applyStimulus(1'b0, '0, 1'b1, 256'(32'h100 + j), 1'b0, 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        checkOutput("t1_valid_before", o_valid, 1'b0);
        i_ready = 1'b1;
        idle();
        checkOutput("t1_latency", o_valid, 1'b1);
        drainWait(0, -1);
        checkOutput("t1_count", got_q.size(), N);
        checkOutput("t1_first", got_q[0], 256'h100);
        checkOutput("t1_last", got_q[N-1], 256'h10F);
        checkOutput("t1_busy_low", busy, 1'b0);

        // 2: sign=0, done before the final sub word
        got_q.delete();
        for (int j = 0; j < N; j++) begin
            applyStimulus(1'b1, 256'(j + 1), 1'b0, '0, 1'b0, 1'b0);
            if (j < N - 1) applyStimulus(1'b0, '0, 1'b1, 256'(32'h100 + j), 1'b0, 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        idle();
        checkOutput("t2_wait_valid", o_valid, 1'b0);
        checkOutput("t2_wait_busy", busy, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 256'h10F, 1'b0, 1'b0);
        checkOutput("t2_valid_before", o_valid, 1'b0);
        i_ready = 1'b1;
        idle();
        checkOutput("t2_latency", o_valid, 1'b1);
        drainWait(0, -1);
        checkOutput("t2_count", got_q.size(), N);
        checkOutput("t2_first", got_q[0], 256'h1);
        checkOutput("t2_last", got_q[N-1], 256'h10);

        // 3: back-pressure 1,0,0,1
        got_q.delete();
        for (int j = 0; j < N; j++)
            applyStimulus(1'b1, 256'(32'h300 + j), 1'b1, 256'(32'h200 + j), 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        idle();
        drainWait(1, -1);
        checkOutput("t3_count", got_q.size(), N);
        for (int j = 0; j < N; j++)
            checkOutput("t3_word", got_q[j], 256'(32'h200 + j));

        // 4: 17th a word, then a sub word mid-drain
        got_q.delete();
        for (int j = 0; j <= N; j++)
            applyStimulus(1'b1, (j == N) ? 256'h999 : 256'(j + 1), 1'b0, '0, 1'b0, 1'b0);
        idle();
        checkOutput("t4_ovf_set", err_ovf, 1'b1);
        for (int j = 0; j < N; j++)
            applyStimulus(1'b0, '0, 1'b1, 256'(32'h400 + j), 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        idle();
        drainWait(0, 3);
        checkOutput("t4_ovf_sticky", err_ovf, 1'b1);
        checkOutput("t4_count", got_q.size(), N);
        for (int j = 0; j < N; j++)
            checkOutput("t4_word", got_q[j], 256'(j + 1));

        // 5: same-cycle strobes with done on the final edge
        got_q.delete();
        for (int j = 0; j < N; j++)
            applyStimulus(1'b1, 256'(32'h500 + j), 1'b1, 256'(32'h600 + j), j == N - 1, 1'b1);
        checkOutput("t5_valid_before", o_valid, 1'b0);
        i_ready = 1'b1;
        idle();
        checkOutput("t5_latency", o_valid, 1'b1);
        drainWait(0, -1);
        checkOutput("t5_first", got_q[0], 256'h600);
        checkOutput("t5_last", got_q[N-1], 256'h60F);

        // 6: reset at rd_ptr=5, then a clean operation
        for (int j = 0; j < N; j++)
            applyStimulus(1'b1, 256'(32'h700 + j), 1'b1, 256'(32'h800 + j), j == N - 1, 1'b1);
        idle();
        i_ready = 1'b1;
        c = 0;
        while (!(o_valid && o_addr == 5) && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        checkOutput("t6_reach_addr5", c < 100, 1'b1);
        rst = 1'b1;
        i_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("t6_valid_low", o_valid, 1'b0);
        checkOutput("t6_busy_low", busy, 1'b0);
        checkOutput("t6_ovf_clear", err_ovf, 1'b0);
        checkOutput("t6_addr_zero", o_addr, '0);
        got_q.delete();
        for (int j = 0; j < N; j++)
            applyStimulus(1'b1, 256'(32'h900 + j), 1'b1, 256'(32'hA00 + j), j == N - 1, 1'b0);
        i_ready = 1'b1;
        idle();
        drainWait(0, -1);
        checkOutput("t6_count", got_q.size(), N);
        checkOutput("t6_first", got_q[0], 256'h900);
        checkOutput("t6_last", got_q[N-1], 256'h90F);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
